// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle signed integer ALU with a valid/ready handshake.
//            Single-cycle ADD/SUB/AND/OR/SLL/SRA. Iterative MUL uses
//            shift-add and DIV uses restoring division, one step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               exception
);

    localparam logic [4:0] c_OP_ADD = 5'd0;
    localparam logic [4:0] c_OP_SUB = 5'd1;
    localparam logic [4:0] c_OP_AND = 5'd2;
    localparam logic [4:0] c_OP_OR  = 5'd3;
    localparam logic [4:0] c_OP_SLL = 5'd4;
    localparam logic [4:0] c_OP_SRA = 5'd5;
    localparam logic [4:0] c_OP_MUL = 5'd6;
    localparam logic [4:0] c_OP_DIV = 5'd7;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DIV  = 2'd2;

    localparam logic [SHAMT_W-1:0] c_LAST = SHAMT_W'(WIDTH - 1);

    // FSM and iteration state
    logic [1:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               neg_q, neg_d;
    // MUL: acc = running product, mcand = shifted multiplicand, mplier = multiplier
    // DIV: acc = remainder, mcand[W-1:0] = divisor, mplier = dividend -> quotient
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               ne_pend_q, ne_pend_d;
    logic               lt_pend_q, lt_pend_d;

    // Output registers
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ne_q, ne_d;
    logic               lt_q, lt_d;
    logic               ovf_q, ovf_d;
    logic               exc_q, exc_d;

    logic               w_accept;
    logic               w_fire_out;
    logic               w_last;
    logic               w_is_mc;
    logic [WIDTH-1:0]   w_sum, w_diff;
    logic               w_add_ovf, w_sub_ovf, w_ne, w_lt;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH-1:0]   w_sc_result;
    logic               w_sc_ovf, w_sc_exc;
    logic [2*WIDTH-1:0] w_acc_mul, w_prod;
    logic               w_mul_ovf;
    logic [WIDTH:0]     w_rem_sh, w_divisor, w_rem_nx;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quo_nx, w_quo_signed;
    logic               w_div_ovf, w_bzero;

    assign w_accept   = in_valid && in_ready;
    assign w_fire_out = out_valid_q && out_ready;
    assign w_last     = (state_q != c_S_IDLE) && (cnt_q == c_LAST);
    assign w_is_mc    = (ctrl_ALUopcode == c_OP_MUL) || (ctrl_ALUopcode == c_OP_DIV);

    // Compare and add/sub on the live request operands
    assign w_sum     = data_operandA + data_operandB;
    assign w_diff    = data_operandA - data_operandB;
    assign w_add_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != data_operandA[WIDTH-1]);
    assign w_sub_ovf = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != data_operandA[WIDTH-1]);
    assign w_ne      = (data_operandA != data_operandB);
    assign w_lt      = w_diff[WIDTH-1] ^ w_sub_ovf;
    // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude
    assign w_abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply step: add the current partial product, then apply the sign
    assign w_acc_mul = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
    assign w_prod    = neg_q ? -w_acc_mul : w_acc_mul;
    assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

    // Divide step: shift in the next dividend bit, subtract if it fits
    assign w_rem_sh     = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    assign w_divisor    = {1'b0, mcand_q[WIDTH-1:0]};
    assign w_ge         = (w_rem_sh >= w_divisor);
    assign w_rem_nx     = w_ge ? (w_rem_sh - w_divisor) : w_rem_sh;
    assign w_quo_nx     = {mplier_q[WIDTH-2:0], w_ge};
    assign w_quo_signed = neg_q ? -w_quo_nx : w_quo_nx;
    // Only MIN / -1 yields a positive quotient with the top bit set
    assign w_div_ovf    = !neg_q && w_quo_nx[WIDTH-1];
    assign w_bzero      = (mcand_q[WIDTH-1:0] == {WIDTH{1'b0}});

    // Result and flags for operations that complete in the accept cycle
    always_comb begin
        w_sc_result = '0;
        w_sc_ovf    = 1'b0;
        w_sc_exc    = 1'b0;
        case (ctrl_ALUopcode)
            c_OP_ADD: begin
                w_sc_result = w_sum;
                w_sc_ovf    = w_add_ovf;
            end
            c_OP_SUB: begin
                w_sc_result = w_diff;
                w_sc_ovf    = w_sub_ovf;
            end
            c_OP_AND: w_sc_result = data_operandA & data_operandB;
            c_OP_OR:  w_sc_result = data_operandA | data_operandB;
            c_OP_SLL: w_sc_result = data_operandA << ctrl_shiftamt;
            c_OP_SRA: w_sc_result = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
            c_OP_MUL, c_OP_DIV: begin
                w_sc_result = '0;
            end
            default:  w_sc_exc = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE: begin
                if (w_accept && (ctrl_ALUopcode == c_OP_MUL)) state_d = c_S_MUL;
                if (w_accept && (ctrl_ALUopcode == c_OP_DIV)) state_d = c_S_DIV;
            end
            c_S_MUL, c_S_DIV: begin
                if (cnt_q == c_LAST) state_d = c_S_IDLE;
            end
            default: state_d = c_S_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the result slot is free or draining
    always_comb begin
        in_ready = (state_q == c_S_IDLE) && (!out_valid_q || out_ready);
    end

    // Datapath and output register next-state
    always_comb begin
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        ne_pend_d   = ne_pend_q;
        lt_pend_d   = lt_pend_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ne_d        = ne_q;
        lt_d        = lt_q;
        ovf_d       = ovf_q;
        exc_d       = exc_q;

        if (w_fire_out) out_valid_d = 1'b0;

        if (w_accept) begin
            cnt_d     = '0;
            neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ne_pend_d = w_ne;
            lt_pend_d = w_lt;
            acc_d     = '0;
            if (ctrl_ALUopcode == c_OP_MUL) begin
                mcand_d  = {{WIDTH{1'b0}}, w_abs_a};
                mplier_d = w_abs_b;
            end else if (ctrl_ALUopcode == c_OP_DIV) begin
                mcand_d  = {{WIDTH{1'b0}}, w_abs_b};
                mplier_d = w_abs_a;
            end
            if (!w_is_mc) begin
                out_valid_d = 1'b1;
                result_d    = w_sc_result;
                ne_d        = w_ne;
                lt_d        = w_lt;
                ovf_d       = w_sc_ovf;
                exc_d       = w_sc_exc;
            end
        end else if (state_q == c_S_MUL) begin
            acc_d    = w_acc_mul;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = w_last ? '0 : cnt_q + 1'b1;
            if (w_last) begin
                out_valid_d = 1'b1;
                result_d    = w_prod[WIDTH-1:0];
                ne_d        = ne_pend_q;
                lt_d        = lt_pend_q;
                ovf_d       = w_mul_ovf;
                exc_d       = 1'b0;
            end
        end else if (state_q == c_S_DIV) begin
            acc_d    = {{(WIDTH-1){1'b0}}, w_rem_nx};
            mplier_d = w_quo_nx;
            cnt_d    = w_last ? '0 : cnt_q + 1'b1;
            if (w_last) begin
                out_valid_d = 1'b1;
                result_d    = w_bzero ? '0 : w_quo_signed;
                ne_d        = ne_pend_q;
                lt_d        = lt_pend_q;
                ovf_d       = w_bzero ? 1'b0 : w_div_ovf;
                exc_d       = w_bzero;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            ne_pend_q   <= 1'b0;
            lt_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ne_q        <= 1'b0;
            lt_q        <= 1'b0;
            ovf_q       <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            ne_pend_q   <= ne_pend_d;
            lt_pend_q   <= lt_pend_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ne_q        <= ne_d;
            lt_q        <= lt_d;
            ovf_q       <= ovf_d;
            exc_q       <= exc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign data_result = result_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;
    assign overflow    = ovf_q;
    assign exception   = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Brief    : Scoreboard bench for alu_mc at WIDTH=32, plus directed and random
//            operations on a WIDTH=8 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  flg;   // {ne, lt, ovf, exc}
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 1;     // 0 random, 1 high, 2 low

    // WIDTH=32 instance
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready;
    logic [W-1:0]  opa = '0, opb = '0, data_result;
    logic [4:0]    opc = '0, shamt = '0;
    logic          ne, lt, ovf, exc;

    // WIDTH=8 instance
    logic          in_valid8 = 1'b0, in_ready8, out_valid8;
    logic          out_ready8 = 1'b1;
    logic [7:0]    opa8 = '0, opb8 = '0, res8;
    logic [4:0]    opc8 = '0;
    logic [2:0]    shamt8 = '0;
    logic          ne8, lt8, ovf8, exc8;

    exp_t q[$];

    alu_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(opa), .data_operandB(opb),
        .ctrl_ALUopcode(opc), .ctrl_shiftamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .isNotEqual(ne), .isLessThan(lt),
        .overflow(ovf), .exception(exc)
    );

    alu_mc #(.WIDTH(8), .SHAMT_W(3)) dut8 (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .data_operandA(opa8), .data_operandB(opb8),
        .ctrl_ALUopcode(opc8), .ctrl_shiftamt(shamt8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .data_result(res8), .isNotEqual(ne8), .isLessThan(lt8),
        .overflow(ovf8), .exception(exc8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: exact integer arithmetic, then reduce to w bits
    function automatic exp_t model(input int w, input logic [4:0] op,
                                   input logic [63:0] au, input logic [63:0] bu, input int sh);
        exp_t   e;
        longint one  = 1;
        longint mask = (one << w) - 1;
        longint maxv = (one << (w - 1)) - 1;
        longint minv = -(one << (w - 1));
        longint a, b, r;
        logic   o, x;
        a = au[w-1] ? longint'(au) - (one << w) : longint'(au);
        b = bu[w-1] ? longint'(bu) - (one << w) : longint'(bu);
        o = 1'b0;
        x = 1'b0;
        case (op)
            5'd0: begin r = a + b; o = (r > maxv) || (r < minv); end
            5'd1: begin r = a - b; o = (r > maxv) || (r < minv); end
            5'd2: r = longint'(au & bu);
            5'd3: r = longint'(au | bu);
            5'd4: r = longint'(au) << sh;
            5'd5: r = a >>> sh;
            5'd6: begin r = a * b; o = (r > maxv) || (r < minv); end
            5'd7: begin
                if (b == 0) begin r = 0; x = 1'b1; end
                else begin r = a / b; o = (r > maxv); end
            end
            default: begin r = 0; x = 1'b1; end
        endcase
        e.res = 64'(r & mask);
        e.flg = {a != b, a < b, o, x};
        e.due = 0;
        return e;
    endfunction

    // Present one request and hold it until accepted; push the expectation
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int acc);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        acc = -1;
        while (!done) begin
            @(negedge clock);
            in_valid = 1'b1; opc = op; opa = a; opb = b; shamt = sh;
            #1;
            if (in_ready) begin
                acc   = cyc + 1;
                e     = model(W, op, {32'b0, a}, {32'b0, b}, int'(sh));
                e.due = acc + ((op == 5'd6 || op == 5'd7) ? W : 0);
                q.push_back(e);
                done  = 1;
            end else if (++n > 200) begin
                check("accept_timeout", {63'b0, in_ready}, 64'd1);
                done = 1;
            end
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) check("drain_empty", 64'(q.size()), 64'd0);
        @(negedge clock);
    endtask

    function automatic logic [31:0] pickv();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] pickop();
        int r = $urandom_range(0, 11);
        if (r < 10) return 5'(r);
        if (r == 10) return 5'h1F;
        return 5'($urandom_range(8, 31));
    endfunction

    // WIDTH=8 single operation: issue, wait bounded for the result, compare
    task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sh);
        exp_t e;
        int   n = 0;
        int   acc;
        @(negedge clock);
        in_valid8 = 1'b1; opc8 = op; opa8 = a; opb8 = b; shamt8 = sh;
        #1;
        while (!in_ready8 && n < 100) begin
            @(negedge clock);
            #1 n++;
        end
        acc   = cyc + 1;
        e     = model(8, op, {56'b0, a}, {56'b0, b}, int'(sh));
        e.due = acc + ((op == 5'd6 || op == 5'd7) ? 8 : 0);
        @(posedge clock);
        #1 in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 100) begin
            @(posedge clock);
            #1 n++;
        end
        check("w8_valid", {63'b0, out_valid8}, 64'd1);
        check("w8_result", {56'b0, res8}, e.res);
        check("w8_flags", {60'b0, ne8, lt8, ovf8, exc8}, {60'b0, e.flg});
        check("w8_latency", 64'(cyc), 64'(e.due));
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clock);
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop one expectation per new result, hold it while stalled
    initial begin
        exp_t cur;
        bit   have = 0;
        cur = '0;
        forever begin
            @(negedge clock);
            #2;
            if (!resetn || !out_valid) begin
                have = 0;
            end else begin
                if (!have) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", {63'b0, out_valid}, 64'd0);
                    end else begin
                        cur = q.pop_front();
                        check("result", {32'b0, data_result}, cur.res);
                        check("flags", {60'b0, ne, lt, ovf, exc}, {60'b0, cur.flg});
                        check("latency", 64'(cyc), 64'(cur.due));
                        have = 1;
                    end
                end else begin
                    check("stall_result", {32'b0, data_result}, cur.res);
                    check("stall_flags", {60'b0, ne, lt, ovf, exc}, {60'b0, cur.flg});
                end
                if (out_ready) have = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        int acc1, acc2, acc_tmp;

        repeat (3) @(negedge clock);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", {32'b0, data_result}, 64'd0);
        check("rst_flags", {60'b0, ne, lt, ovf, exc}, 64'd0);
        check("rst_valid8", {63'b0, out_valid8}, 64'd0);
        resetn = 1'b1;
        #1 check("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Directed single-cycle operations
        rdy_mode = 1;
        issue(5'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, acc_tmp);
        issue(5'd1, 32'd5, 32'd7, 5'd0, acc_tmp);
        issue(5'd5, 32'h8000_0000, 32'h0, 5'd31, acc_tmp);
        issue(5'd4, 32'h1, 32'h0, 5'd31, acc_tmp);
        issue(5'd4, 32'hA5A5_1234, 32'h0, 5'd0, acc_tmp);
        issue(5'd5, 32'h8765_4321, 32'h0, 5'd0, acc_tmp);
        issue(5'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3, acc1);
        issue(5'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3, acc2);
        check("back_to_back", 64'(acc2 - acc1), 64'd1);
        issue(5'd8, 32'h1, 32'h2, 5'd0, acc_tmp);
        issue(5'h1F, 32'h3, 32'h3, 5'd0, acc_tmp);

        // Directed multi-cycle operations
        issue(5'd6, 32'hFFFF_FFF9, 32'd6, 5'd0, acc_tmp);
        issue(5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, acc_tmp);
        issue(5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, acc_tmp);
        issue(5'd7, 32'hFFFF_FFF9, 32'd2, 5'd0, acc_tmp);
        issue(5'd7, 32'd9, 32'd0, 5'd0, acc_tmp);
        issue(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, acc_tmp);
        drain();

        // Backpressure: result must hold and no new request may enter
        repeat (2) @(negedge clock);
        rdy_mode = 2;
        issue(5'd0, 32'd3, 32'd4, 5'd0, acc_tmp);
        @(negedge clock);
        in_valid = 1'b1; opc = 5'd1; opa = 32'd9; opb = 32'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", {63'b0, in_ready}, 64'd0);
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            if (i == 4) rdy_mode = 1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        issue(5'd1, 32'd9, 32'd2, 5'd0, acc_tmp);
        issue(5'd0, 32'd5, 32'd6, 5'd0, acc_tmp);
        drain();

        // Reset in the middle of a divide
        issue(5'd7, 32'hFFFF_FF9C, 32'd3, 5'd0, acc_tmp);
        repeat (9) @(negedge clock);
        #3 resetn = 1'b0;
        #1;
        check("midrst_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_result", {32'b0, data_result}, 64'd0);
        check("midrst_flags", {60'b0, ne, lt, ovf, exc}, 64'd0);
        q.delete();
        @(negedge clock);
        #3 resetn = 1'b1;
        #1 check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        issue(5'd0, 32'd1, 32'd1, 5'd0, acc_tmp);
        drain();

        // Randomised traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 200; i++) begin
            issue(pickop(), pickv(), pickv(), 5'($urandom_range(0, 31)), acc_tmp);
            if ($urandom_range(0, 4) == 0) @(negedge clock);
        end
        rdy_mode = 1;
        drain();

        // WIDTH=8 instance
        run8(5'd6, 8'h80, 8'h01, 3'd0);
        run8(5'd6, 8'h80, 8'h80, 3'd0);
        run8(5'd7, 8'h80, 8'hFF, 3'd0);
        run8(5'd7, 8'h07, 8'h00, 3'd0);
        run8(5'd5, 8'h80, 8'h00, 3'd7);
        run8(5'd0, 8'h7F, 8'h01, 3'd0);
        for (int i = 0; i < 30; i++) begin
            run8(5'($urandom_range(0, 9)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
